tlb_walker: RTL and testbench
=============================

Name: tlb_walker

Overview:
- Page-table walker that responds to TLB misses.
- Accepts a miss (va, pcid) from the TLB and walks an NLEVEL radix page table in memory through a simple request/acknowledge read port.
- On success it returns a one-cycle fill carrying the translated address, which drives the TLB's insert/pa inputs.
- On failure it raises a one-cycle fault.

Parameters:
SADDR, 64, address width (virtual and physical)
SPAGE, 12, page offset width
SPCID, 12, process-context identifier width
NLEVEL, 3, page-table levels (>=2)
SIDX, 9, index bits per level; one PTE is 8 bytes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_valid  in  1  TLB miss request
miss_ready  out  1  walker idle, accepts miss
miss_va  in  SADDR  missing virtual address
miss_pcid  in  SPCID  pcid of miss
ptbr  in  SADDR  root table physical base, 4 KiB aligned
mem_req  out  1  read request, level-held until mem_ack
mem_addr  out  SADDR  PTE physical address
mem_ack  in  1  read data valid this cycle
mem_rdata  in  SADDR  PTE
fill_valid  out  1  one-cycle insert pulse to TLB
fill_va  out  SADDR  latched va
fill_pcid  out  SPCID  latched pcid
fill_pa  out  SADDR  translated address including page offset
fault  out  1  one-cycle walk-failure pulse

Behaviour:
- Reset values: miss_ready=1, mem_req=0, mem_addr=0, fill_valid=0, fill_va=0, fill_pa=0, fill_pcid=0, fault=0, state=IDLE, level=NLEVEL-1.
- PTE format: bit0 V (valid), bit1 L (leaf), PPN = pte[SADDR-1:SPAGE]; all other bits ignored.
- Index for level k: va[SPAGE+SIDX*(k+1)-1 : SPAGE+SIDX*k]. va bits at or above SPAGE+SIDX*NLEVEL are ignored.
- PTE address: {table_ppn, SPAGE'b0} | (idx<<3). Root table_ppn = ptbr[SADDR-1:SPAGE].
- IDLE:
  - miss_ready=1.
  - On miss_valid, latch va and pcid, set level=NLEVEL-1, go to LOOKUP.
  - ptbr is sampled once, at acceptance.
- LOOKUP:
  - mem_req=1, mem_addr stable, miss_ready=0.
  - Waits any number of cycles for mem_ack. mem_ack is sampled only in LOOKUP and ignored in all other states.
  - On mem_ack, evaluate mem_rdata:
    - V=0 -> FAULT.
    - V=1, L=1 -> DONE.
    - V=1, L=0, level>0 -> level-1, table_ppn=PPN, stay in LOOKUP with the new mem_addr on the next cycle. mem_req stays high; a back-to-back ack is allowed.
    - V=1, L=0, level=0 -> FAULT.
- Superpage: a leaf at level k>0 forms fill_pa[SADDR-1:SPAGE] from the PPN, with its low SIDX*k bits replaced by va bits. The offset is always va[SPAGE-1:0].
- DONE: fill_valid=1 for exactly one cycle, with fill_pa/fill_va/fill_pcid valid in that cycle, then IDLE.
- FAULT: fault=1 for exactly one cycle, no fill, then IDLE. fill_* registers hold their previous values.
- Latency: miss accepted in cycle 0; first mem_req in cycle 1. With mem_ack in the same cycle as each request, fill_valid appears in cycle NLEVEL+1.
- A new miss is accepted in the cycle after DONE/FAULT (IDLE). There is no pipelining and there are no queued misses.
- rst mid-walk:
  - Abandons the walk in the next cycle: mem_req drops, no fill, no fault.
  - A mem_ack arriving after reset is ignored.

Optional Feature:
- Macro WALK_CACHE_EN.
- Defined:
  - Adds a single-entry cache of the last level-0 table PPN, tagged by pcid, the va index bits of levels NLEVEL-1..1, and ptbr. The tag is written when a level-1 non-leaf PTE is consumed.
  - On a tag match at miss accept, the walk starts directly at level 0 with the cached table PPN (one memory read).
  - The entry is invalidated by rst, by a fault, or by a ptbr mismatch.
- Undefined: no cache; every walk starts at level NLEVEL-1.

Test Plan:
- Full walk:
  - Setup: ptbr=0x1000, va=0x40403ABC, pcid=5.
  - Reads in order: 0x1008 -> 0x2001, 0x2010 -> 0x3001, 0x3018 -> 0x7003.
  - Expect: fill_valid pulse with fill_pa=0x7ABC, fill_pcid=5; mem_req never seen in IDLE.
- Superpage:
  - Setup: same va; 0x1008 -> 0x2001, 0x2010 -> 0x400003.
  - Expect: fill_pa=0x403ABC after 2 reads.
- Faults:
  - Case 1: 0x1008 -> 0x2000 (V=0). Expect: fault pulse after 1 read, fill_valid stays 0.
  - Case 2: non-leaf PTE at level 0. Expect: fault pulse, fill_valid stays 0.
- Handshake stall:
  - Stimulus: mem_ack delayed 5 cycles per read.
  - Expect: mem_req and mem_addr stable throughout; miss_ready=0 until the cycle after fill_valid.
  - Also: a miss_valid presented while busy is not accepted.
- Reset mid-walk:
  - Stimulus: assert rst during the second LOOKUP, then a stray mem_ack.
  - Expect: mem_req=0 and miss_ready=1 next cycle; no fill, no fault; the next miss walks normally from ptbr.
- WALK_CACHE_EN:
  - Stimulus: repeat the full walk with va=0x40404123.
  - Expect: a single read at 0x3020 and fill_pa=0x7123 only if 0x3020 returns 0x7003; with the macro undefined, 3 reads.

Source files
------------

// File: rtl/tlb_walker_if.sv
// rtl/tlb_walker_if.sv - miss, memory-read and fill/fault signals between TLB, walker and memory
// The walker connects through the slave modport; the TLB/memory side uses master.
interface tlb_walker_if #(
  parameter int SADDR = 64,
  parameter int SPCID = 12
);
  logic             miss_valid;
  logic             miss_ready;
  logic [SADDR-1:0] miss_va;
  logic [SPCID-1:0] miss_pcid;
  logic [SADDR-1:0] ptbr;
  logic             mem_req;
  logic [SADDR-1:0] mem_addr;
  logic             mem_ack;
  logic [SADDR-1:0] mem_rdata;
  logic             fill_valid;
  logic [SADDR-1:0] fill_va;
  logic [SPCID-1:0] fill_pcid;
  logic [SADDR-1:0] fill_pa;
  logic             fault;

  modport slave (
    input  miss_valid, miss_va, miss_pcid, ptbr, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, fill_valid, fill_va, fill_pcid, fill_pa, fault
  );

  modport master (
    output miss_valid, miss_va, miss_pcid, ptbr, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, fill_valid, fill_va, fill_pcid, fill_pa, fault
  );
endinterface

// File: rtl/tlb_walker.sv
// rtl/tlb_walker.sv - NLEVEL radix page-table walker answering TLB misses with a fill or fault
// Optional WALK_CACHE_EN adds a one-entry cache of the last level-0 table PPN.
module tlb_walker #(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SPCID  = 12,
  parameter int NLEVEL = 3,
  parameter int SIDX   = 9
) (
  input  logic         clk,
  input  logic         rst,
  tlb_walker_if.slave  bus
);
  localparam int PW  = SADDR - SPAGE;
  localparam int LW  = (NLEVEL > 2) ? $clog2(NLEVEL) : 1;
  localparam int VLO = SPAGE + SIDX;
  localparam int VHI = SPAGE + SIDX * NLEVEL - 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE, FAULT} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SADDR-1:0] va_q, va_d;
  logic [SPCID-1:0] pcid_q, pcid_d;
  logic [PW-1:0]    table_q, table_d;
  logic             miss_ready_q, miss_ready_d;
  logic             mem_req_q, mem_req_d;
  logic [SADDR-1:0] mem_addr_q, mem_addr_d;
  logic             fill_valid_q, fill_valid_d;
  logic [SADDR-1:0] fill_va_q, fill_va_d;
  logic [SPCID-1:0] fill_pcid_q, fill_pcid_d;
  logic [SADDR-1:0] fill_pa_q, fill_pa_d;
  logic             fault_q, fault_d;
  logic [PW-1:0]    pte_ppn, sp_mask;
  logic             unused_bits;

`ifdef WALK_CACHE_EN
  logic                         cache_valid_q, cache_valid_d;
  logic [SPCID-1:0]             cache_pcid_q, cache_pcid_d;
  logic [SIDX*(NLEVEL-1)-1:0]   cache_vtag_q, cache_vtag_d;
  logic [PW-1:0]                cache_ptbr_q, cache_ptbr_d;
  logic [PW-1:0]                cache_ppn_q, cache_ppn_d;
  logic [PW-1:0]                root_q, root_d;
`endif

  function automatic logic [SADDR-1:0] pte_addr(input logic [PW-1:0] tbl,
                                                input logic [SADDR-1:0] va,
                                                input logic [LW-1:0] lvl);
    logic [SADDR-1:0] sh;
    sh = va >> (SPAGE + SIDX * int'(lvl));
    return {tbl, {SPAGE{1'b0}}} | ({{(SADDR-SIDX){1'b0}}, sh[SIDX-1:0]} << 3);
  endfunction

  assign pte_ppn     = bus.mem_rdata[SADDR-1:SPAGE];
  assign sp_mask     = {PW{1'b1}} << (SIDX * int'(level_q));
  assign unused_bits = ^{bus.mem_rdata[SPAGE-1:2], bus.ptbr[SPAGE-1:0]};

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    va_d        = va_q;
    pcid_d      = pcid_q;
    table_d     = table_q;
    fill_va_d   = fill_va_q;
    fill_pcid_d = fill_pcid_q;
    fill_pa_d   = fill_pa_q;
`ifdef WALK_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_pcid_d  = cache_pcid_q;
    cache_vtag_d  = cache_vtag_q;
    cache_ptbr_d  = cache_ptbr_q;
    cache_ppn_d   = cache_ppn_q;
    root_d        = root_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.miss_valid) begin
          va_d    = bus.miss_va;
          pcid_d  = bus.miss_pcid;
          level_d = LW'(NLEVEL - 1);
          table_d = bus.ptbr[SADDR-1:SPAGE];
          state_d = LOOKUP;
`ifdef WALK_CACHE_EN
          root_d = bus.ptbr[SADDR-1:SPAGE];
          if (cache_valid_q && cache_ptbr_q != bus.ptbr[SADDR-1:SPAGE]) begin
            cache_valid_d = 1'b0;
          end else if (cache_valid_q && cache_pcid_q == bus.miss_pcid &&
                       cache_vtag_q == bus.miss_va[VHI:VLO]) begin
            level_d = '0;
            table_d = cache_ppn_q;
          end
`endif
        end
      end
      LOOKUP: begin
        if (bus.mem_ack) begin
          if (!bus.mem_rdata[0]) begin
            state_d = FAULT;
          end else if (bus.mem_rdata[1]) begin
            // Superpage leaves keep the va bits below their level as part of the PPN.
            state_d     = DONE;
            fill_va_d   = va_q;
            fill_pcid_d = pcid_q;
            fill_pa_d   = {(pte_ppn & sp_mask) | (va_q[SADDR-1:SPAGE] & ~sp_mask),
                           va_q[SPAGE-1:0]};
          end else if (level_q != '0) begin
            level_d = LW'(level_q - 1'b1);
            table_d = pte_ppn;
`ifdef WALK_CACHE_EN
            if (level_q == LW'(1)) begin
              cache_valid_d = 1'b1;
              cache_pcid_d  = pcid_q;
              cache_vtag_d  = va_q[VHI:VLO];
              cache_ptbr_d  = root_q;
              cache_ppn_d   = pte_ppn;
            end
`endif
          end else begin
            state_d = FAULT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef WALK_CACHE_EN
    if (state_d == FAULT) cache_valid_d = 1'b0;
`endif
    miss_ready_d = (state_d == IDLE);
    mem_req_d    = (state_d == LOOKUP);
    mem_addr_d   = (state_d == LOOKUP) ? pte_addr(table_d, va_d, level_d) : mem_addr_q;
    fill_valid_d = (state_d == DONE);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= LW'(NLEVEL - 1);
      va_q         <= '0;
      pcid_q       <= '0;
      table_q      <= '0;
      miss_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_va_q    <= '0;
      fill_pcid_q  <= '0;
      fill_pa_q    <= '0;
      fault_q      <= 1'b0;
`ifdef WALK_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_pcid_q  <= '0;
      cache_vtag_q  <= '0;
      cache_ptbr_q  <= '0;
      cache_ppn_q   <= '0;
      root_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      va_q         <= va_d;
      pcid_q       <= pcid_d;
      table_q      <= table_d;
      miss_ready_q <= miss_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_va_q    <= fill_va_d;
      fill_pcid_q  <= fill_pcid_d;
      fill_pa_q    <= fill_pa_d;
      fault_q      <= fault_d;
`ifdef WALK_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_pcid_q  <= cache_pcid_d;
      cache_vtag_q  <= cache_vtag_d;
      cache_ptbr_q  <= cache_ptbr_d;
      cache_ppn_q   <= cache_ppn_d;
      root_q        <= root_d;
`endif
    end
  end

  assign bus.miss_ready = miss_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_va    = fill_va_q;
  assign bus.fill_pcid  = fill_pcid_q;
  assign bus.fill_pa    = fill_pa_q;
  assign bus.fault      = fault_q;
endmodule

// File: tb/tb_tlb_walker.sv
// tb/tb_tlb_walker.sv - directed bench for tlb_walker: walks, superpage, faults, stall, reset
// Inputs change and outputs are sampled on the falling edge.
module tb_tlb_walker;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  tlb_walker_if #(.SADDR(64), .SPCID(12)) bus ();

  tlb_walker dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_miss(input logic [63:0] va, input logic [11:0] pcid);
    chk("idle_ready", bus.miss_ready, 1);
    chk("idle_no_req", bus.mem_req, 0);
    bus.miss_valid = 1'b1;
    bus.miss_va    = va;
    bus.miss_pcid  = pcid;
    @(negedge clk);
    bus.miss_valid = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [63:0] addr, input logic [63:0] data,
                       input int delay);
    chk({tag, "_req"}, bus.mem_req, 1);
    chk({tag, "_addr"}, bus.mem_addr, addr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_hold_req"}, bus.mem_req, 1);
      chk({tag, "_hold_addr"}, bus.mem_addr, addr);
      chk({tag, "_busy"}, bus.miss_ready, 0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic expect_fill(input string tag, input logic [63:0] pa, input logic [63:0] va,
                             input logic [11:0] pcid);
    chk({tag, "_fill_valid"}, bus.fill_valid, 1);
    chk({tag, "_fill_pa"}, bus.fill_pa, pa);
    chk({tag, "_fill_va"}, bus.fill_va, va);
    chk({tag, "_fill_pcid"}, bus.fill_pcid, 64'(pcid));
    chk({tag, "_no_fault"}, bus.fault, 0);
    chk({tag, "_ready_low"}, bus.miss_ready, 0);
    chk({tag, "_req_low"}, bus.mem_req, 0);
    @(negedge clk);
    chk({tag, "_fill_pulse"}, bus.fill_valid, 0);
    chk({tag, "_ready_back"}, bus.miss_ready, 1);
  endtask

  task automatic expect_fault(input string tag);
    chk({tag, "_fault"}, bus.fault, 1);
    chk({tag, "_no_fill"}, bus.fill_valid, 0);
    chk({tag, "_req_low"}, bus.mem_req, 0);
    @(negedge clk);
    chk({tag, "_fault_pulse"}, bus.fault, 0);
    chk({tag, "_no_fill2"}, bus.fill_valid, 0);
    chk({tag, "_ready_back"}, bus.miss_ready, 1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.miss_valid = 1'b0;
    bus.miss_va    = '0;
    bus.miss_pcid  = '0;
    bus.ptbr       = 64'h1000;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_miss_ready", bus.miss_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_pa", bus.fill_pa, 0);
    chk("rst_fill_va", bus.fill_va, 0);
    chk("rst_fill_pcid", bus.fill_pcid, 0);
    chk("rst_fault", bus.fault, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored_pre", bus.mem_req, 0);

    // Superpage leaf at level 1
    start_miss(64'h4040_3ABC, 12'd5);
    serve("sp_l2", 64'h1008, 64'h2001, 0);
    serve("sp_l1", 64'h2010, 64'h40_0003, 0);
    expect_fill("sp", 64'h40_3ABC, 64'h4040_3ABC, 12'd5);

    // Invalid root PTE; fill registers keep the superpage result
    start_miss(64'h4040_3ABC, 12'd5);
    serve("f1_l2", 64'h1008, 64'h2000, 0);
    expect_fault("f1");
    chk("f1_fill_pa_hold", bus.fill_pa, 64'h40_3ABC);

    // Non-leaf at level 0
    start_miss(64'h4040_3ABC, 12'd5);
    serve("f2_l2", 64'h1008, 64'h2001, 0);
    serve("f2_l1", 64'h2010, 64'h3001, 0);
    serve("f2_l0", 64'h3018, 64'h5001, 0);
    expect_fault("f2");

    // Full three-level walk, ack in the request cycle
    start_miss(64'h4040_3ABC, 12'd5);
    serve("fw_l2", 64'h1008, 64'h2001, 0);
    serve("fw_l1", 64'h2010, 64'h3001, 0);
    serve("fw_l0", 64'h3018, 64'h7003, 0);
    expect_fill("fw", 64'h7ABC, 64'h4040_3ABC, 12'd5);

    // Same upper indices and pcid: cache hit reads level 0 only
    start_miss(64'h4040_4123, 12'd5);
`ifdef WALK_CACHE_EN
    serve("wc_l0", 64'h3020, 64'h7003, 0);
`else
    serve("wc_l2", 64'h1008, 64'h2001, 0);
    serve("wc_l1", 64'h2010, 64'h3001, 0);
    serve("wc_l0", 64'h3020, 64'h7003, 0);
`endif
    expect_fill("wc", 64'h7123, 64'h4040_4123, 12'd5);

    // Stalled acks with a competing miss presented while busy
    start_miss(64'h4040_3ABC, 12'd9);
    bus.miss_valid = 1'b1;
    bus.miss_va    = 64'h0000_0000_1234_5678;
    bus.miss_pcid  = 12'd1;
    serve("st_l2", 64'h1008, 64'h2001, 5);
    bus.miss_valid = 1'b0;
    serve("st_l1", 64'h2010, 64'h3001, 5);
    serve("st_l0", 64'h3018, 64'h7003, 5);
    expect_fill("st", 64'h7ABC, 64'h4040_3ABC, 12'd9);

    // Reset during the second lookup, then a stray ack
    start_miss(64'h4040_3ABC, 12'd5);
    serve("rm_l2", 64'h1008, 64'h2001, 0);
    chk("rm_l1_req", bus.mem_req, 1);
    chk("rm_l1_addr", bus.mem_addr, 64'h2010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_req_drop", bus.mem_req, 0);
    chk("rm_ready", bus.miss_ready, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h3001;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    chk("rm_stray_req", bus.mem_req, 0);
    chk("rm_stray_fill", bus.fill_valid, 0);
    chk("rm_stray_fault", bus.fault, 0);
    @(negedge clk);
    chk("rm_stray_fill2", bus.fill_valid, 0);
    chk("rm_stray_fault2", bus.fault, 0);
    start_miss(64'h4040_3ABC, 12'd5);
    serve("rw_l2", 64'h1008, 64'h2001, 0);
    serve("rw_l1", 64'h2010, 64'h3001, 0);
    serve("rw_l0", 64'h3018, 64'h7003, 0);
    expect_fill("rw", 64'h7ABC, 64'h4040_3ABC, 12'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
